// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller: forwarding selects and
// default address/latency widths.
package hazard_pkg;
  localparam int REG_AW_DEF = 5;
  localparam int LAT_W_DEF  = 4;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
endpackage

// File: rtl/mc_scoreboard.sv
// Multi-cycle unit tracking: per-register pending-write bits, the latency
// countdown and the latched destination of the op in flight.
module mc_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int LAT_W  = LAT_W_DEF,
  localparam int NUM_REGS = 2**REG_AW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_i,
  input  logic [REG_AW-1:0]   issue_rd_i,
  input  logic [LAT_W-1:0]    issue_lat_i,
  output logic [NUM_REGS-1:0] pending_o,
  output logic                mc_busy_o,
  output logic                mc_wb_valid_o,
  output logic [REG_AW-1:0]   mc_wb_rd_o
);

  localparam logic [LAT_W-1:0] CNT_ONE = LAT_W'(1);

  logic [LAT_W-1:0]    count_q, count_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [REG_AW-1:0]   rd_q, rd_d;

  always_comb begin
    count_d   = count_q;
    pending_d = pending_q;
    rd_d      = rd_q;
    if (count_q != '0) count_d = count_q - CNT_ONE;
    if (count_q == CNT_ONE) pending_d[rd_q] = 1'b0;
    // A new issue in the completion cycle must win over the clear above.
    if (issue_i) begin
      count_d = (issue_lat_i == '0) ? CNT_ONE : issue_lat_i;
      rd_d    = issue_rd_i;
      if (issue_rd_i != '0) pending_d[issue_rd_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      pending_q <= '0;
      rd_q      <= '0;
    end else begin
      count_q   <= count_d;
      pending_q <= pending_d;
      rd_q      <= rd_d;
    end
  end

  assign pending_o     = pending_q;
  assign mc_busy_o     = (count_q != '0);
  assign mc_wb_valid_o = (count_q == CNT_ONE);
  assign mc_wb_rd_o    = rd_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard controller for the 5-stage core: load-use, branch flush, forwarding,
// multi-cycle unit scoreboard and data-memory wait freeze.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int LAT_W  = LAT_W_DEF,
  localparam int NUM_REGS = 2**REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] de_rs1,
  input  logic [REG_AW-1:0] de_rs2,
  input  logic [REG_AW-1:0] de_rd,
  input  logic              de_reg_write,
  input  logic              de_mc_op,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_result_src0,
  input  logic              ex_pc_src,
  input  logic              ex_mc_op,
  input  logic [LAT_W-1:0]  ex_mc_lat,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              mem_reg_write,
  input  logic              wb_reg_write,
  input  logic              mem_wait,
  output logic              if_stall,
  output logic              de_stall,
  output logic              ex_stall,
  output logic              mem_stall,
  output logic              de_flush,
  output logic              ex_flush,
  output logic              wb_flush,
  output logic [1:0]        ex_op1_forward,
  output logic [1:0]        ex_op2_forward,
  output logic              mc_busy,
  output logic              mc_wb_valid,
  output logic [REG_AW-1:0] mc_wb_rd
);

  logic [NUM_REGS-1:0] pending;
  logic                mc_issue;
  logic                load_use, sb_raw, sb_waw, mc_struct, de_hazard;

  // A frozen EX stage must not issue; it issues once mem_wait drops.
  assign mc_issue = ex_mc_op & ~mem_wait;

  mc_scoreboard #(.REG_AW(REG_AW), .LAT_W(LAT_W)) u_mc_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_i       (mc_issue),
    .issue_rd_i    (ex_rd),
    .issue_lat_i   (ex_mc_lat),
    .pending_o     (pending),
    .mc_busy_o     (mc_busy),
    .mc_wb_valid_o (mc_wb_valid),
    .mc_wb_rd_o    (mc_wb_rd)
  );

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic              mem_we,
    input logic [REG_AW-1:0] mem_dst,
    input logic              wb_we,
    input logic [REG_AW-1:0] wb_dst
  );
    if (mem_we && mem_dst != '0 && mem_dst == rs) return FWD_MEM;
    if (wb_we && wb_dst != '0 && wb_dst == rs)    return FWD_WB;
    return FWD_RF;
  endfunction

  always_comb begin
    load_use  = ex_result_src0 && ex_rd != '0 && (ex_rd == de_rs1 || ex_rd == de_rs2);
    sb_raw    = (de_rs1 != '0 && pending[de_rs1]) || (de_rs2 != '0 && pending[de_rs2]);
    sb_waw    = de_reg_write && de_rd != '0 && pending[de_rd];
    // count > 1 is busy without completing; the count == 1 cycle frees the unit.
    mc_struct = de_mc_op && ((mc_busy && !mc_wb_valid) || ex_mc_op);
    de_hazard = load_use || sb_raw || sb_waw || mc_struct;
  end

  always_comb begin
    if_stall  = 1'b0;
    de_stall  = 1'b0;
    ex_stall  = 1'b0;
    mem_stall = 1'b0;
    de_flush  = 1'b0;
    ex_flush  = 1'b0;
    wb_flush  = 1'b0;
    if (mem_wait) begin
      if_stall  = 1'b1;
      de_stall  = 1'b1;
      ex_stall  = 1'b1;
      mem_stall = 1'b1;
      wb_flush  = 1'b1;
    end else if (ex_pc_src) begin
      de_flush = 1'b1;
      ex_flush = 1'b1;
    end else if (de_hazard) begin
      if_stall = 1'b1;
      de_stall = 1'b1;
      ex_flush = 1'b1;
    end
  end

  always_comb begin
    ex_op1_forward = fwd_sel(ex_rs1, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
    ex_op2_forward = fwd_sel(ex_rs2, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
  end

endmodule
